// File: rtl/buffer_pkg.sv
// Shared types and constants for the buffer slot arbiter.
package buffer_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_STALL = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEFAULT = 32;
  localparam int STALL_CNT_W    = 32;

endpackage

// File: rtl/buffer_slot_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [PTR_W-1:0]   pick_o,
  output logic               any_req_o
);

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    pick_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[rot_idx(ptr_i, k)]) pick_o = rot_idx(ptr_i, k);
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/buffer_slot_arbiter.sv
// Round-robin valid/ready arbiter sharing one buffer slot between NUM_REQ requesters.
// Optional macro STALL_PERF_CNT_EN enables the saturating stall_cycles counter.
module buffer_slot_arbiter
  import buffer_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MAX_HOLD = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         slot_inputs,
  output logic                      slot_stall,
  input  logic                      slot_to_stall_mgmt,
  input  logic                      downstream_stall,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      hold_timeout,
  output logic [31:0]               stall_cycles
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // Handshake: a beat moves on a rising clk edge where req_valid[i] & req_ready[i].
  // Requesters hold valid and data stable until that beat.
  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                hold_timeout_q, hold_timeout_d;

  logic                stall_any;
  logic [ID_W-1:0]     gid_next;
  logic [NUM_REQ-1:0]  gid_onehot;
  logic [NUM_REQ-1:0]  pick_req;
  logic [ID_W-1:0]     pick_ptr;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  assign stall_any  = downstream_stall | slot_to_stall_mgmt;
  assign gid_next   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
  assign gid_onehot = NUM_REQ'(1) << grant_id_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // While granted, the picker looks ahead for the back-to-back successor,
  // excluding the current grantee and starting just past it.
  assign pick_req = (state_q == ARB_GRANT) ? (req_valid & ~gid_onehot) : req_valid;
  assign pick_ptr = (state_q == ARB_GRANT) ? gid_next : rr_ptr_q;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(ID_W)) u_picker (
    .req_i     (pick_req),
    .ptr_i     (pick_ptr),
    .pick_o    (pick_idx),
    .any_req_o (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (stall_any) begin
          state_d    = ARB_STALL;
          hold_cnt_d = HOLD_W'(1);
        end else if (req_valid[grant_id_q]) begin
          rr_ptr_d = gid_next;
          if (pick_any) grant_id_d = pick_idx;
          else          state_d    = ARB_IDLE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_STALL: begin
        if (stall_any) begin
          if (hold_cnt_q != HOLD_W'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          state_d    = ARB_GRANT;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Registered so the pulse lands in the first cycle the count reads MAX_HOLD.
  assign hold_timeout_d = (state_d == ARB_STALL) && (hold_cnt_d == HOLD_W'(MAX_HOLD)) &&
                          (hold_cnt_q != HOLD_W'(MAX_HOLD));

  always_comb begin
    req_ready   = '0;
    slot_inputs = '0;
    slot_stall  = 1'b0;
    grant_valid = 1'b0;
    case (state_q)
      ARB_GRANT: begin
        grant_valid = 1'b1;
        slot_inputs = data_arr[grant_id_q];
        req_ready   = stall_any ? '0 : gid_onehot;
      end
      ARB_STALL: begin
        grant_valid = 1'b1;
        slot_inputs = data_arr[grant_id_q];
        slot_stall  = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_id     = grant_id_q;
  assign hold_timeout = hold_timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] perf_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt_q <= '0;
    end else if (state_q == ARB_STALL && perf_cnt_q != '1) begin
      perf_cnt_q <= perf_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = perf_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_buffer_slot_arbiter.sv
// Bench for buffer_slot_arbiter: reset, vector table, stall/timeout/perf sequences,
// and randomized traffic against a transaction-level reference model.
module tb_buffer_slot_arbiter;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int MAX_HOLD = 8;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   slot_inputs;
  logic           slot_stall;
  logic           slot_to_stall_mgmt;
  logic           downstream_stall;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           hold_timeout;
  logic [31:0]    stall_cycles;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  buffer_slot_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .slot_inputs        (slot_inputs),
    .slot_stall         (slot_stall),
    .slot_to_stall_mgmt (slot_to_stall_mgmt),
    .downstream_stall   (downstream_stall),
    .grant_valid        (grant_valid),
    .grant_id           (grant_id),
    .hold_timeout       (hold_timeout),
    .stall_cycles       (stall_cycles)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic ds, input logic stm);
    req_valid          = v;
    downstream_stall   = ds;
    slot_to_stall_mgmt = stm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic load_fixed_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA0 + i;
  endtask

  // ---------------- reference model ----------------
  bit m_grant, m_stall, m_to;
  int m_owner, m_ptr, m_hold;
  longint m_perf;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_stall = 0; m_to = 0;
    m_owner = 0; m_ptr = 0; m_hold = 0; m_perf = 0;
  endtask

  // One clock edge worth of arbitration; done = requester that completed a beat.
  task automatic model_step(input logic [N-1:0] v, input logic sa, output int done);
    logic [N-1:0] others;
    int nh;
    done = -1;
    m_to = 0;
    if (m_stall) m_perf++;
    if (!m_grant) begin
      if (v != 0) begin
        m_owner = rr_pick(m_ptr, v);
        m_grant = 1;
      end
    end else if (!m_stall) begin
      if (sa) begin
        m_stall = 1;
        m_hold  = 1;
        m_to    = (MAX_HOLD == 1);
      end else if (v[m_owner]) begin
        done   = m_owner;
        m_ptr  = (m_owner + 1) % N;
        others = v;
        others[m_owner] = 1'b0;
        if (others != 0) m_owner = rr_pick(m_ptr, others);
        else             m_grant = 0;
      end else begin
        m_grant = 0;
      end
    end else begin
      if (sa) begin
        nh     = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
        m_to   = (nh == MAX_HOLD) && (m_hold != MAX_HOLD);
        m_hold = nh;
      end else begin
        m_stall = 0;
        m_hold  = 0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] v;
    logic         ds;
    logic         stm;
    logic [N-1:0] rdy;
    logic         gv;
    logic [1:0]   gid;
    logic         ss;
    logic [W-1:0] si;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int pulses;
    int done;
    int burst;
    logic [N-1:0] exp_rdy;
    logic         sa;
    logic [W-1:0] popped;

    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 32'hA0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hA1};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'hA2};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 32'hA2};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 32'hA2};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 32'hA3};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 32'hA0};
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hA1};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[10] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 32'hA2};
    tbl[11] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[12] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 32'hA3};
    tbl[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 32'hA0};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[15] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 32'hA2};
    tbl[17] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hA1};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};

    // ---- reset state ----
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gv",    64'(grant_valid),  64'(0));
    check("rst_ready", 64'(req_ready),    64'(0));
    check("rst_si",    64'(slot_inputs),  64'(0));
    check("rst_ss",    64'(slot_stall),   64'(0));
    check("rst_gid",   64'(grant_id),     64'(0));
    check("rst_to",    64'(hold_timeout), 64'(0));
    check("rst_perf",  64'(stall_cycles), 64'(0));
    reset = 1'b1;
    next_cycle();

    // ---- table-driven vectors ----
    load_fixed_data();
    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].v, tbl[r].ds, tbl[r].stm);
      @(negedge clk);
      check($sformatf("tbl%0d_ready", r), 64'(req_ready),    64'(tbl[r].rdy));
      check($sformatf("tbl%0d_gv", r),    64'(grant_valid),  64'(tbl[r].gv));
      check($sformatf("tbl%0d_ss", r),    64'(slot_stall),   64'(tbl[r].ss));
      check($sformatf("tbl%0d_si", r),    64'(slot_inputs),  64'(tbl[r].si));
      check($sformatf("tbl%0d_to", r),    64'(hold_timeout), 64'(0));
      if (tbl[r].gv) check($sformatf("tbl%0d_gid", r), 64'(grant_id), 64'(tbl[r].gid));
      next_cycle();
    end

    // ---- hold timeout: stall indication held 12 cycles on grantee 2 ----
    drive(4'b0100, 1'b0, 1'b0);
    next_cycle();
    drive(4'b0100, 1'b0, 1'b1);
    @(negedge clk);
    check("to_grant_ready", 64'(req_ready), 64'(0));
    check("to_grant_gid",   64'(grant_id),  64'(2));
    next_cycle();
    pulses = 0;
    for (int s = 1; s <= 11; s++) begin
      @(negedge clk);
      if (hold_timeout) pulses++;
      check($sformatf("to_s%0d_pulse", s), 64'(hold_timeout), 64'(s == 8));
      check($sformatf("to_s%0d_gid", s),   64'(grant_id),     64'(2));
      check($sformatf("to_s%0d_ss", s),    64'(slot_stall),   64'(1));
      next_cycle();
    end
    drive(4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    check("to_exit_pulse", 64'(hold_timeout), 64'(0));
    next_cycle();
    @(negedge clk);
    check("to_resume_ready", 64'(req_ready), 64'(4'b0100));
    check("to_pulse_count",  64'(pulses),    64'(1));
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    next_cycle();

    // ---- asynchronous reset in the middle of a grant ----
    drive(4'b1111, 1'b0, 1'b0);
    next_cycle();
    check("pre_rst_gv", 64'(grant_valid), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("async_rst_gv",    64'(grant_valid), 64'(0));
    check("async_rst_ready", 64'(req_ready),   64'(0));
    check("async_rst_si",    64'(slot_inputs), 64'(0));
    check("async_rst_ss",    64'(slot_stall),  64'(0));
    next_cycle();
    check("held_rst_gv",    64'(grant_valid), 64'(0));
    check("held_rst_ready", 64'(req_ready),   64'(0));
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_rst_gv",    64'(grant_valid), 64'(1));
    check("post_rst_gid",   64'(grant_id),    64'(0));
    check("post_rst_ready", 64'(req_ready),   64'(4'b0001));
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    next_cycle();
    next_cycle();

    // ---- stall cycle counter: exactly five cycles in the stalled state ----
    pulse_reset();
    drive(4'b0001, 1'b0, 1'b0);
    next_cycle();
    drive(4'b0001, 1'b0, 1'b1);
    repeat (5) next_cycle();
    drive(4'b0001, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    check("perf_count",  64'(stall_cycles), PERF_EN ? 64'(5) : 64'(0));
    check("perf_ready",  64'(req_ready),    64'(4'b0001));
    check("perf_gid",    64'(grant_id),     64'(0));
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    next_cycle();

    // ---- randomized traffic against the reference model ----
    pulse_reset();
    model_reset();
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = $urandom;
        end
      end
      if (burst > 0) burst--;
      else if ($urandom_range(0, 60) == 0) burst = $urandom_range(6, 12);
      slot_to_stall_mgmt = (burst > 0) || ($urandom_range(0, 19) == 0);
      downstream_stall   = ($urandom_range(0, 9) == 0);

      @(negedge clk);
      sa = downstream_stall | slot_to_stall_mgmt;
      exp_rdy = (m_grant && !m_stall && !sa) ? N'(1) << m_owner : '0;
      check("rnd_ready", 64'(req_ready),    64'(exp_rdy));
      check("rnd_gv",    64'(grant_valid),  64'(m_grant));
      check("rnd_ss",    64'(slot_stall),   64'(m_grant && m_stall));
      check("rnd_si",    64'(slot_inputs),  m_grant ? 64'(req_data[m_owner*W +: W]) : 64'(0));
      check("rnd_to",    64'(hold_timeout), 64'(m_to));
      check("rnd_perf",  64'(stall_cycles), PERF_EN ? 64'(m_perf) : 64'(0));
      if (m_grant) check("rnd_gid", 64'(grant_id), 64'(m_owner));
      if ((exp_rdy & req_valid) != 0) exp_q.push_back(req_data[m_owner*W +: W]);
      if ((req_ready & req_valid) != 0) begin
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("rnd_beat_data", 64'(slot_inputs), 64'(popped));
        end else begin
          total++;
          bad++;
          $display("FAIL rnd_beat_unexpected: got beat with data %0h expected none", slot_inputs);
        end
      end

      @(posedge clk);
      model_step(req_valid, sa, done);
      #1;
      if (done >= 0) req_valid[done] = 1'b0;
    end
    check("rnd_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_slot_arbiter.md
Name: buffer_slot_arbiter

Overview:
- Shares one buffer_slots instance between NUM_REQ requesters using a round-robin valid/ready handshake.
- Drives the slot's data input and stall input.
- Merges the downstream stall with the slot's to_stall_mgmt indication.
- Flags grants held stalled for too long.

Parameters:
- NUM_REQ, 4, number of requesters (>=1)
- DATA_W, 32, data width; matches the buffer slot width
- MAX_HOLD, 8, consecutive stalled cycles under one grant before hold_timeout pulses (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset; all state clears while low
- req_valid  in  NUM_REQ  per-requester valid
- req_data  in  NUM_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero
- slot_inputs  out  DATA_W  data to the buffer slot's inputs port
- slot_stall  out  1  stall to the buffer slot
- slot_to_stall_mgmt  in  1  stall indication from the buffer slot
- downstream_stall  in  1  stall from the consumer of the slot outputs
- grant_valid  out  1  a grant is active (ARB_GRANT or ARB_STALL)
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current grantee
- hold_timeout  out  1  one-cycle pulse on stall-hold expiry
- stall_cycles  out  32  stalled-cycle count (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous):
  - state=ARB_IDLE; rr_ptr=0; grant_id=0; hold_cnt=0
  - all outputs 0
  - any in-flight transfer is dropped; no partial state survives
- Stall source: stall_any = downstream_stall | slot_to_stall_mgmt.
- Round-robin pick: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... with wrap-around modulo NUM_REQ.
- ARB_IDLE:
  - req_ready=0; slot_inputs=0; slot_stall=0.
  - If any req_valid: register grant_id=pick and go to ARB_GRANT.
  - Latency from first req_valid to req_ready is 1 cycle.
- ARB_GRANT:
  - slot_inputs = req_data[grant_id]; req_ready[grant_id] = !stall_any; slot_stall=0.
  - Transfer = req_valid[grant_id] & req_ready[grant_id].
  - On transfer: rr_ptr = grant_id+1; wraps NUM_REQ-1 -> 0.
    - If any other req_valid this cycle: re-pick from the new rr_ptr and stay in ARB_GRANT (back-to-back, no bubble).
    - Otherwise go to ARB_IDLE.
  - If stall_any: go to ARB_STALL; no transfer; hold_cnt=1.
  - If req_valid[grant_id] drops without a transfer (protocol violation): go to ARB_IDLE; rr_ptr unchanged.
- ARB_STALL:
  - slot_stall=1; req_ready=0; slot_inputs keeps the grantee's data; grant_id frozen.
  - hold_cnt increments, saturating at MAX_HOLD.
  - hold_timeout=1 for exactly one cycle, on the cycle hold_cnt transitions to MAX_HOLD. The grant is still held.
  - When stall_any clears: return to ARB_GRANT with the same grantee; hold_cnt=0.
- Simultaneous events:
  - Stall asserted in the same cycle as valid: stall wins; ready=0, no transfer.
  - Requester i asserting valid during a grant to j waits for its round-robin turn.
- Guarantees:
  - Starvation-free: every held request is granted within NUM_REQ grants.
  - NUM_REQ=1 degenerates to a single handshake pass-through with one-cycle grant latency.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit saturating counter (stops at 0xFFFF_FFFF) of cycles in ARB_STALL.
  - Cleared only by reset.
- Undefined:
  - stall_cycles tied to 0; no counter flops synthesized.
  - The port is always present.

Decomposition:
- Package buffer_pkg:
  - typedef enum arb_state_e {ARB_IDLE, ARB_GRANT, ARB_STALL}
  - localparam DATA_W_DEFAULT=32
  - localparam STALL_CNT_W=32
- Sub-module rr_picker: combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: pick index, any_req.
- The arbiter instantiates rr_picker once.

Test Plan:
- Reset: hold reset low mid-grant with req_valid=4'b1111 -> next edge shows grant_valid=0, req_ready=0, slot_inputs=0, slot_stall=0; after release, the first grant goes to id 0.
- Round-robin: req_valid=4'b1111 held, data i=32'hA0+i, no stalls -> grant order 0,1,2,3,0; one transfer per cycle after the first 1-cycle latency; slot_inputs matches 32'hA0..A3.
- Stall priority: in ARB_GRANT on id 2, assert downstream_stall together with valid -> req_ready=0, slot_stall=1 next cycle, no transfer; release -> id 2 transfers, then id 3 is granted.
- Timeout: hold slot_to_stall_mgmt for 12 cycles with MAX_HOLD=8 -> hold_timeout high exactly once, in the 8th stalled cycle; grant_id unchanged throughout.
- Wrap and sparse: req_valid=4'b1001 with rr_ptr=3 -> grant 3 then 0, then ARB_IDLE once valids drop.
- With STALL_PERF_CNT_EN: 5 stalled cycles -> stall_cycles=5. Without the macro: stall_cycles stays 0.
